// File: rtl/lcd_page_sched.sv
// Rotates up to three two-row LCD pages held in per-slot capture buffers.
// Define ALARM_PREEMPT_EN to make slot 2 an alarm page that preempts rotation.
module lcd_page_sched #(
    parameter int unsigned DWELL_CYC    = 150_000_000,
    parameter int unsigned MIN_HOLD_CYC = 3_400_000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [2:0]   src_vld,
    input  logic [383:0] src_row1,
    input  logic [383:0] src_row2,
    input  logic [2:0]   src_clr,
    output logic [2:0]   src_ack,
    output logic [127:0] row_1,
    output logic [127:0] row_2,
    output logic [1:0]   page_sel,
    output logic         page_upd
);
    localparam int unsigned CNT_MAX =
        (DWELL_CYC > MIN_HOLD_CYC) ? DWELL_CYC : MIN_HOLD_CYC;
    localparam int CNT_W = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_TOP    = CNT_W'(CNT_MAX);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYC - 1);
`ifdef ALARM_PREEMPT_EN
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(MIN_HOLD_CYC - 1);
`endif
    localparam logic [127:0] BLANK = {16{8'h20}};

    typedef enum logic [1:0] {IDLE, NEXT, SHOW} state_t;

    state_t              state_q, state_d;
    logic [2:0][127:0]   b1_q, b1_d, b2_q, b2_d;
    logic [2:0]          full_q, full_d;
    logic [2:0]          ack_q, ack_d;
    logic [127:0]        row1_q, row1_d, row2_q, row2_d;
    logic [1:0]          sel_q, sel_d;
    logic                upd_q, upd_d;
    logic                first_q, first_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc;
    logic [1:0]          base, pick, idx;
    logic                hit;

    function automatic logic [1:0] mod3(input logic [2:0] v);
        logic [2:0] s;
        s = (v >= 3'd3) ? v - 3'd3 : v;
        return s[1:0];
    endfunction

    always_comb begin
        b1_d   = b1_q;
        b2_d   = b2_q;
        full_d = full_q;
        ack_d  = '0;
        for (int i = 0; i < 3; i++) begin
            if (src_vld[i]) begin
                b1_d[i]   = src_row1[128*i +: 128];
                b2_d[i]   = src_row2[128*i +: 128];
                full_d[i] = 1'b1;
                ack_d[i]  = 1'b1;
            end else if (src_clr[i]) begin
                full_d[i] = 1'b0;
            end
        end
    end

    // Reverse scan so the earliest slot in search order wins.
    always_comb begin
        base = first_q ? 2'd0 : mod3({1'b0, sel_q} + 3'd1);
        hit  = 1'b0;
        pick = sel_q;
        idx  = 2'd0;
        for (int k = 2; k >= 0; k--) begin
            idx = mod3({1'b0, base} + 3'(k));
            if (full_q[idx]) begin
                hit  = 1'b1;
                pick = idx;
            end
        end
`ifdef ALARM_PREEMPT_EN
        if (full_q[2]) begin
            hit  = 1'b1;
            pick = 2'd2;
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        row1_d  = row1_q;
        row2_d  = row2_q;
        upd_d   = 1'b0;
        cnt_d   = cnt_q;
        first_d = first_q;
        cnt_inc = (cnt_q == CNT_TOP) ? cnt_q : cnt_q + CNT_W'(1);
        unique case (state_q)
            IDLE: begin
                if (|full_q) begin
                    state_d = NEXT;
                    first_d = 1'b1;
                end
            end
            NEXT: begin
                first_d = 1'b0;
                upd_d   = 1'b1;
                if (hit) begin
                    sel_d   = pick;
                    row1_d  = b1_q[pick];
                    row2_d  = b2_q[pick];
                    cnt_d   = '0;
                    state_d = SHOW;
                end else begin
                    row1_d  = BLANK;
                    row2_d  = BLANK;
                    state_d = IDLE;
                end
            end
            SHOW: begin
                cnt_d = cnt_inc;
                // Fresh capture into the shown slot: refresh, keep dwell.
                if (ack_q[sel_q]) begin
                    row1_d = b1_q[sel_q];
                    row2_d = b2_q[sel_q];
                    upd_d  = 1'b1;
                end
                if (!full_q[sel_q] || (src_clr[sel_q] && !src_vld[sel_q])
                    || cnt_inc >= DWELL_LAST)
                    state_d = NEXT;
`ifdef ALARM_PREEMPT_EN
                if (full_q[2] && sel_q != 2'd2 && cnt_inc >= HOLD_LAST)
                    state_d = NEXT;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            b1_q    <= {3{BLANK}};
            b2_q    <= {3{BLANK}};
            full_q  <= '0;
            ack_q   <= '0;
            row1_q  <= BLANK;
            row2_q  <= BLANK;
            sel_q   <= '0;
            upd_q   <= 1'b0;
            first_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            b1_q    <= b1_d;
            b2_q    <= b2_d;
            full_q  <= full_d;
            ack_q   <= ack_d;
            row1_q  <= row1_d;
            row2_q  <= row2_d;
            sel_q   <= sel_d;
            upd_q   <= upd_d;
            first_q <= first_d;
            cnt_q   <= cnt_d;
        end
    end

    assign src_ack  = ack_q;
    assign row_1    = row1_q;
    assign row_2    = row2_q;
    assign page_sel = sel_q;
    assign page_upd = upd_q;
endmodule
